load_store_sched: RTL

LOAD_STORE_SCHED -- requirements
Module: load_store_sched

---
 rtl/load_store_sched_pkg.sv | 21 ++
 rtl/load_store_sched_if.sv | 33 +++
 rtl/load_store_sched_rr_arbiter.sv | 37 +++
 rtl/load_store_sched.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/load_store_sched_pkg.sv
// ============================================================================
// load_store_pkg : shared state encoding and default sizing for load_store_sched
// Revision: 1.0
// ============================================================================
`default_nettype none

package load_store_pkg;

    localparam int N_DEFAULT     = 200000;
    localparam int CBITS_DEFAULT = 18;
    localparam int NREQ_DEFAULT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/load_store_sched_if.sv
// ============================================================================
// load_store_sched_if : requester bus (req/dir/amt in, grant/status out)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface load_store_sched_if #(
    parameter int NREQ  = 4,
    parameter int CBITS = 18
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       dir;
    logic [NREQ*CBITS-1:0] amt;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic                  sat;
    logic [CBITS-1:0]      vol;
    logic                  full;
    logic                  empty;

    modport master (
        output req, dir, amt,
        input  gnt, busy, done, sat, vol, full, empty
    );

    modport slave (
        input  req, dir, amt,
        output gnt, busy, done, sat, vol, full, empty
    );
endinterface

`default_nettype wire

// File: rtl/load_store_sched_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, first request at or after ptr
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o
);

    int   pos;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos = (int'(ptr_i) + i) % NREQ;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = PW'(pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/load_store_sched.sv
// ============================================================================
// load_store_sched : round-robin scheduler moving units into/out of a bounded
//                    tank, one requester transfer at a time.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_sched
    import load_store_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int CBITS = CBITS_DEFAULT,
    parameter int NREQ  = NREQ_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    load_store_sched_if.slave  bus
);

    localparam int               PW      = $clog2(NREQ);
    localparam logic [CBITS-1:0] VOL_MAX = CBITS'(N);

    state_e           state_q, state_d;
    logic [CBITS-1:0] vol_q,   vol_d;
    logic [CBITS-1:0] rem_q,   rem_d;
    logic [PW-1:0]    ptr_q,   ptr_d;
    logic [PW-1:0]    idx_q,   idx_d;
    logic             dir_q,   dir_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic             done_q,  done_d;
    logic             sat_q,   sat_d;
    logic             busy_q,  busy_d;
    logic             full_q,  full_d;
    logic             empty_q, empty_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [PW-1:0]    arb_idx;
    logic             at_bound;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign at_bound = dir_q ? (vol_q == VOL_MAX) : (vol_q == '0);

    always_comb begin
        state_d = state_q;
        vol_d   = vol_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        sat_d   = sat_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                // Request fields are captured only here; later changes are ignored.
                if (|bus.req) begin
                    state_d = ST_XFER;
                    gnt_d   = arb_gnt;
                    idx_d   = arb_idx;
                    dir_d   = bus.dir[arb_idx];
                    rem_d   = bus.amt[int'(arb_idx)*CBITS +: CBITS];
                    busy_d  = 1'b1;
                    sat_d   = 1'b0;
                end
            end
            ST_XFER: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    sat_d   = 1'b0;
                end else if (at_bound) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    sat_d   = 1'b1;
                end else begin
                    vol_d = dir_q ? (vol_q + CBITS'(1)) : (vol_q - CBITS'(1));
                    rem_d = rem_q - CBITS'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                done_d  = 1'b0;
                sat_d   = 1'b0;
                busy_d  = 1'b0;
                ptr_d   = (idx_q == PW'(NREQ - 1)) ? '0 : (idx_q + PW'(1));
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
        full_d  = (vol_d == VOL_MAX);
        empty_d = (vol_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vol_q   <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            vol_q   <= vol_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sat   = sat_q;
    assign bus.vol   = vol_q;
    assign bus.full  = full_q;
    assign bus.empty = empty_q;

endmodule

`default_nettype wire
